wait_func_arbiter: RTL and testbench
====================================

Name: wait_func_arbiter

Overview:
- Shares one cycle-wait unit among NREQ kernel-side requesters. The unit has an Avalon-ST request/response handshake: it accepts a wait count and returns the elapsed cycle count.
- Picks one requester with a round-robin policy and forwards its wait value to the unit. Holds the grant until the unit's result has been delivered back to that requester.
- Exactly one transaction is outstanding at a time. Sits between the requester lanes and a single wait-unit instance in the BSP-side test design.

Parameters:
- NREQ, 4, number of requesters; must be 2..16.
- WIDTH, 64, width of wait value and result.
- IDW, $clog2(NREQ), width of the requester index (derived; not overridden).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept; one-hot or zero.
- req_value  in  NREQ*WIDTH  packed wait values; lane i is bits [i*WIDTH +: WIDTH].
- rsp_valid  out  NREQ  per-requester result valid; one-hot or zero.
- rsp_ready  in  NREQ  per-requester result accept.
- rsp_value  out  WIDTH  result, shared by all lanes; qualified by rsp_valid.
- wu_valid  out  1  request valid to the wait unit.
- wu_ready  in  1  wait unit ready for a request.
- wu_value  out  WIDTH  wait count to the wait unit.
- wu_rsp_valid  in  1  wait unit result valid.
- wu_rsp_ready  out  1  result accept to the wait unit.
- wu_rsp_value  in  WIDTH  wait unit result.
- busy  out  1  high in any state other than IDLE.
- grant_count  out  32  number of completed transactions; wraps modulo 2^32.

Behaviour:
- FSM states are IDLE, ISSUE, WAIT, RETURN. Reset puts the FSM in IDLE.
- Reset values:
  - ptr=0, cur_id=0, grant_count=0.
  - Latched value and latched result are 0.
  - All valid/ready outputs are 0, and busy=0.
- IDLE, grant selection:
  - The winner is the first set bit of req_valid, scanning from ptr upward and wrapping at NREQ.
  - req_ready is the one-hot of the winner and is combinational from req_valid. No other lane sees ready.
  - With no req_valid bit set, req_ready=0.
  - On req_valid[w]&req_ready[w]:
    - latch value=req_value[w] and cur_id=w;
    - ptr <= (w+1) mod NREQ, wrapping NREQ-1 to 0;
    - go to ISSUE.
- ISSUE:
  - wu_valid=1 and wu_value=latched value; both held stable until wu_ready.
  - On wu_valid&wu_ready, go to WAIT. wu_valid is 0 in the following cycle.
- WAIT:
  - wu_rsp_ready=1.
  - On wu_rsp_valid, latch wu_rsp_value and go to RETURN.
- RETURN:
  - rsp_valid[cur_id]=1 and rsp_value=latched result.
  - On rsp_ready[cur_id], grant_count increments (wrapping at 2^32) and the FSM goes to IDLE.
  - rsp_ready on any other lane is ignored.
- Handshake rules:
  - A transfer happens only on a cycle where valid&ready are both 1.
  - Once asserted, the block's valids stay high until accepted.
- Minimum latency: request accept -> wu_valid 1 cycle; wu_rsp_valid -> rsp_valid 1 cycle.
- Back-to-back transactions: a new grant is possible in the cycle after a RETURN handshake, because IDLE is entered that cycle.
- Simultaneous requests: exactly one lane is granted per IDLE cycle. The others keep valid and are served in round-robin order. No lane starves: wait is at most NREQ-1 transactions.
- wu_rsp_valid outside WAIT is ignored, and wu_rsp_ready=0 there.
- Reset mid-operation: any state returns to IDLE next cycle with all outputs at reset values, and the in-flight result is dropped. The wait unit shares RST, so its in-flight operation is also cleared.
- A value of 0 is forwarded unchanged; the arbiter does not interpret values.

Decomposition:
- Shared package wait_pkg holds:
  - state enum (IDLE=0, ISSUE=1, WAIT=2, RETURN=3);
  - GRANT_COUNT_W=32.
- One natural sub-module: rr_pick. It is combinational: inputs req vector and ptr; outputs one-hot grant, grant index and any-valid flag. It is reused by future multi-resource schedulers.

Test Plan:
- Single lane 2 requests value=10 -> wu_value=10 one cycle after accept; result 11 returned on rsp_valid[2]/rsp_value=11; grant_count=1; busy low after handshake.
- All 4 lanes valid continuously from reset -> grant order 0,1,2,3,0; exactly one req_ready bit high per IDLE cycle.
- wu_ready held low 5 cycles in ISSUE -> wu_valid and wu_value stay stable all 5 cycles; exactly one transfer.
- rsp_ready[1] held low 7 cycles with rsp_ready[0] high -> rsp_valid[1] stays high; lane 0 unaffected; no new grant until lane 1 accepts.
- RST asserted in WAIT with wu_rsp_valid pulsing -> next cycle: IDLE, all valids 0, ptr=0, grant_count=0; no response delivered.
- 2^32 completions forced via a preloaded count of 0xFFFFFFFF -> next completion gives grant_count=0.

Source files
------------

// File: rtl/wait_func_arbiter_pkg.sv
// Shared definitions for the wait-unit arbiter and future schedulers that
// drive cycle-wait units.
//   state_t        : arbiter FSM encoding
//   GRANT_COUNT_W  : width of the completed-transaction counter
package wait_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } state_t;

  localparam int GRANT_COUNT_W = 32;

endpackage

// File: rtl/wait_func_arbiter_if.sv
// Handshake bundle between the requester lanes, the arbiter and the shared
// wait unit.
//   req_*    : per-lane request (valid/ready per lane, values packed by lane)
//   rsp_*    : per-lane response (valid/ready per lane, one shared value)
//   wu_*     : request/response channel to the single wait unit
// Modports:
//   slave  : the arbiter
//   master : the environment (requesters plus the wait unit)
interface wait_func_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_value;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_value;
  logic                  wu_valid;
  logic                  wu_ready;
  logic [WIDTH-1:0]      wu_value;
  logic                  wu_rsp_valid;
  logic                  wu_rsp_ready;
  logic [WIDTH-1:0]      wu_rsp_value;

  modport slave (
    input  req_valid, req_value, rsp_ready, wu_ready, wu_rsp_valid, wu_rsp_value,
    output req_ready, rsp_valid, rsp_value, wu_valid, wu_value, wu_rsp_ready
  );

  modport master (
    output req_valid, req_value, rsp_ready, wu_ready, wu_rsp_valid, wu_rsp_value,
    input  req_ready, rsp_valid, rsp_value, wu_valid, wu_value, wu_rsp_ready
  );

endinterface

// File: rtl/wait_func_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority lane for this pick
//   gnt_o : one-hot grant (zero when nothing requests)
//   idx_o : index of the granted lane (0 when nothing requests)
//   any_o : at least one request present
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int k;

  // Scan from ptr_i upward with wrap; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int off = 0; off < NREQ; off++) begin
      k = (int'(ptr_i) + off) % NREQ;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/wait_func_arbiter.sv
// Round-robin arbiter sharing one cycle-wait unit among NREQ requesters.
// One transaction is outstanding at a time; the grant is held until the
// unit's result has been accepted by the granted lane.
// Ports:
//   CLK, RST           : clock, synchronous active-high reset
//   bus                : handshake bundle (slave side)
//   cnt_load_i         : load grant_count with cnt_load_value_i (bring-up hook)
//   cnt_load_value_i   : value loaded into grant_count
//   busy_o             : FSM not in IDLE
//   grant_count_o      : completed transactions, wraps modulo 2^32
// NREQ must be 2..16.
//
// state  | meaning
// IDLE   | picking a requester; req_ready is the combinational grant
// ISSUE  | presenting the latched value to the wait unit
// WAIT   | waiting for the wait unit result
// RETURN | presenting the result to the granted lane
module wait_func_arbiter
  import wait_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  wait_func_arbiter_if.slave       bus,
  input  logic                     cnt_load_i,
  input  logic [GRANT_COUNT_W-1:0] cnt_load_value_i,
  output logic                     busy_o,
  output logic [GRANT_COUNT_W-1:0] grant_count_o
);

  localparam int IDW = $clog2(NREQ);

  state_t                   state_q;
  logic [IDW-1:0]           ptr_q, ptr_d;
  logic [IDW-1:0]           cur_id_q;
  logic [WIDTH-1:0]         value_q;
  logic [WIDTH-1:0]         result_q;
  logic [GRANT_COUNT_W-1:0] grant_count_q, grant_count_d;

  logic [NREQ-1:0]          pick_gnt;
  logic [IDW-1:0]           pick_idx;
  logic                     pick_any;
  logic [NREQ-1:0]          cur_oh;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    ptr_d         = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    grant_count_d = grant_count_q + GRANT_COUNT_W'(1);
    cur_oh        = '0;
    cur_oh[cur_id_q] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cur_id_q      <= '0;
      value_q       <= '0;
      result_q      <= '0;
      grant_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // pick_any implies the granted lane has valid, so this is the
          // req_valid & req_ready transfer.
          if (pick_any) begin
            value_q  <= bus.req_value[int'(pick_idx)*WIDTH +: WIDTH];
            cur_id_q <= pick_idx;
            ptr_q    <= ptr_d;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.wu_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (bus.wu_rsp_valid) begin
            result_q <= bus.wu_rsp_value;
            state_q  <= RETURN;
          end
        end
        RETURN: begin
          if (bus.rsp_ready[cur_id_q]) begin
            grant_count_q <= grant_count_d;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (cnt_load_i) grant_count_q <= cnt_load_value_i;
    end
  end

  // Valids are decodes of the state register; only req_ready is
  // combinational from req_valid so a grant costs no extra cycle.
  assign bus.req_ready    = (state_q == IDLE)   ? pick_gnt : '0;
  assign bus.wu_valid     = (state_q == ISSUE);
  assign bus.wu_value     = value_q;
  assign bus.wu_rsp_ready = (state_q == WAIT);
  assign bus.rsp_valid    = (state_q == RETURN) ? cur_oh : '0;
  assign bus.rsp_value    = result_q;
  assign busy_o           = (state_q != IDLE);
  assign grant_count_o    = grant_count_q;

endmodule

// File: tb/tb_wait_func_arbiter.sv
module tb_wait_func_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 64;

  logic        CLK;
  logic        RST;
  logic        cnt_load;
  logic [31:0] cnt_load_value;
  logic        busy;
  logic [31:0] grant_count;

  int errors = 0;
  int checks = 0;

  wait_func_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  wait_func_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .bus              (bus),
    .cnt_load_i       (cnt_load),
    .cnt_load_value_i (cnt_load_value),
    .busy_o           (busy),
    .grant_count_o    (grant_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [WIDTH-1:0] v);
    bus.req_value[lane*WIDTH +: WIDTH] = v;
  endtask

  // Drives the wait unit and the response side from ISSUE through the
  // RETURN handshake with minimum latency.
  task automatic complete_txn(input int lane, input logic [WIDTH-1:0] res);
    bus.wu_ready = 1'b1;
    tick();
    bus.wu_ready     = 1'b0;
    bus.wu_rsp_valid = 1'b1;
    bus.wu_rsp_value = res;
    tick();
    bus.wu_rsp_valid = 1'b0;
    bus.rsp_ready    = '0;
    bus.rsp_ready[lane] = 1'b1;
    tick();
    bus.rsp_ready = '0;
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
    checks++; if (bus.wu_valid !== 1'b0 || bus.wu_rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_wu: got valid=%b rsp_ready=%b want 0 0", bus.wu_valid, bus.wu_rsp_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", grant_count); end
    checks++; if (bus.wu_value !== 64'd0 || bus.rsp_value !== 64'd0) begin errors++; $display("FAIL reset_values: got wu=%0h rsp=%0h want 0 0", bus.wu_value, bus.rsp_value); end
  endtask

  task automatic test_single();
    tick();
    bus.req_valid = 4'b0100;
    set_lane(2, 64'd10);
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    #1;
    checks++; if (bus.wu_valid !== 1'b1 || bus.wu_value !== 64'd10) begin errors++; $display("FAIL single_issue: got valid=%b value=%0d want 1 10", bus.wu_valid, bus.wu_value); end
    checks++; if (busy !== 1'b1 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_busy: got busy=%b req_ready=%b want 1 0000", busy, bus.req_ready); end
    bus.wu_ready = 1'b1;
    tick();
    bus.wu_ready = 1'b0;
    #1;
    checks++; if (bus.wu_valid !== 1'b0 || bus.wu_rsp_ready !== 1'b1) begin errors++; $display("FAIL single_wait: got wu_valid=%b wu_rsp_ready=%b want 0 1", bus.wu_valid, bus.wu_rsp_ready); end
    bus.wu_rsp_valid = 1'b1;
    bus.wu_rsp_value = 64'd11;
    tick();
    bus.wu_rsp_valid = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_value !== 64'd11) begin errors++; $display("FAIL single_rsp: got valid=%b value=%0d want 0100 11", bus.rsp_valid, bus.rsp_value); end
    checks++; if (bus.wu_rsp_ready !== 1'b0) begin errors++; $display("FAIL single_rsp_wu_ready: got %b want 0", bus.wu_rsp_ready); end
    bus.rsp_ready = 4'b0100;
    tick();
    bus.rsp_ready = 4'b0000;
    #1;
    checks++; if (grant_count !== 32'd1 || busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_done: got count=%0d busy=%b rsp_valid=%b want 1 0 0000", grant_count, busy, bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_oh;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 64'(100 + i));
    bus.req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      exp_oh = 4'b0001 << exp_order[n];
      checks++; if (bus.req_ready !== exp_oh || $countones(bus.req_ready) != 1) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", n, bus.req_ready, exp_oh); end
      tick();
      checks++; if (bus.wu_value !== 64'(100 + exp_order[n])) begin errors++; $display("FAIL rr_value%0d: got %0d want %0d", n, bus.wu_value, 100 + exp_order[n]); end
      complete_txn(exp_order[n], 64'(200 + n));
    end
    bus.req_valid = 4'b0000;
    #1;
    checks++; if (grant_count !== 32'd5) begin errors++; $display("FAIL rr_count: got %0d want 5", grant_count); end
  endtask

  // ptr is 1 on entry; only lane 0 requests, so lane 0 wins after wrap.
  task automatic test_issue_stall();
    int transfers = 0;
    bus.req_valid = 4'b0001;
    set_lane(0, 64'h55);
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL stall_grant: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    bus.wu_ready  = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.wu_valid !== 1'b1 || bus.wu_value !== 64'h55) begin errors++; $display("FAIL stall_hold%0d: got valid=%b value=%0h want 1 55", c, bus.wu_valid, bus.wu_value); end
      if (bus.wu_valid && bus.wu_ready) transfers++;
      tick();
    end
    bus.wu_ready = 1'b1;
    #1;
    if (bus.wu_valid && bus.wu_ready) transfers++;
    tick();
    bus.wu_ready = 1'b0;
    #1;
    if (bus.wu_valid && bus.wu_ready) transfers++;
    checks++; if (transfers != 1) begin errors++; $display("FAIL stall_transfers: got %0d want 1", transfers); end
    checks++; if (bus.wu_valid !== 1'b0 || bus.wu_rsp_ready !== 1'b1) begin errors++; $display("FAIL stall_wait: got wu_valid=%b wu_rsp_ready=%b want 0 1", bus.wu_valid, bus.wu_rsp_ready); end
    bus.wu_rsp_valid = 1'b1;
    bus.wu_rsp_value = 64'h56;
    tick();
    bus.wu_rsp_valid = 1'b0;
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = 4'b0000;
    #1;
    checks++; if (grant_count !== 32'd6) begin errors++; $display("FAIL stall_count: got %0d want 6", grant_count); end
  endtask

  // ptr is 1 on entry; lanes 0 and 1 request, lane 1 wins. Value 0 must
  // pass through unchanged.
  task automatic test_rsp_hold();
    bus.req_valid = 4'b0011;
    set_lane(0, 64'd5);
    set_lane(1, 64'd0);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL hold_grant: got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.wu_valid !== 1'b1 || bus.wu_value !== 64'd0) begin errors++; $display("FAIL hold_zero: got valid=%b value=%0d want 1 0", bus.wu_valid, bus.wu_value); end
    bus.wu_ready = 1'b1;
    tick();
    bus.wu_ready     = 1'b0;
    bus.wu_rsp_valid = 1'b1;
    bus.wu_rsp_value = 64'd77;
    tick();
    bus.wu_rsp_valid = 1'b0;
    bus.rsp_ready    = 4'b0001;
    #1;
    for (int c = 0; c < 7; c++) begin
      checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_value !== 64'd77 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL hold_cycle%0d: got rsp_valid=%b value=%0d req_ready=%b want 0010 77 0000", c, bus.rsp_valid, bus.rsp_value, bus.req_ready); end
      tick();
    end
    bus.rsp_ready = 4'b0010;
    tick();
    bus.rsp_ready = 4'b0000;
    #1;
    checks++; if (grant_count !== 32'd7 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL hold_done: got count=%0d rsp_valid=%b want 7 0000", grant_count, bus.rsp_valid); end
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL hold_next_grant: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    #1;
    checks++; if (bus.wu_value !== 64'd5) begin errors++; $display("FAIL hold_lane0_value: got %0d want 5", bus.wu_value); end
    complete_txn(0, 64'd6);
    checks++; if (grant_count !== 32'd8) begin errors++; $display("FAIL hold_count2: got %0d want 8", grant_count); end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 4'b1000;
    set_lane(3, 64'd9);
    tick();
    bus.req_valid = 4'b0000;
    bus.wu_ready  = 1'b1;
    tick();
    bus.wu_ready = 1'b0;
    #1;
    checks++; if (bus.wu_rsp_ready !== 1'b1) begin errors++; $display("FAIL mid_in_wait: got %b want 1", bus.wu_rsp_ready); end
    RST = 1'b1;
    bus.wu_rsp_valid = 1'b1;
    bus.wu_rsp_value = 64'd99;
    tick();
    RST = 1'b0;
    bus.wu_rsp_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.wu_valid !== 1'b0 || bus.wu_rsp_ready !== 1'b0) begin errors++; $display("FAIL mid_outputs: got busy=%b rsp_valid=%b wu_valid=%b wu_rsp_ready=%b want 0 0000 0 0", busy, bus.rsp_valid, bus.wu_valid, bus.wu_rsp_ready); end
    checks++; if (grant_count !== 32'd0 || bus.rsp_value !== 64'd0 || bus.wu_value !== 64'd0) begin errors++; $display("FAIL mid_values: got count=%0d rsp=%0d wu=%0d want 0 0 0", grant_count, bus.rsp_value, bus.wu_value); end
    bus.wu_rsp_valid = 1'b1;
    tick();
    bus.wu_rsp_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_ignore_rsp: got busy=%b rsp_valid=%b want 0 0000", busy, bus.rsp_valid); end
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr: got %b want 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_count_wrap();
    tick();
    cnt_load       = 1'b1;
    cnt_load_value = 32'hFFFF_FFFF;
    tick();
    cnt_load = 1'b0;
    #1;
    checks++; if (grant_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_load: got %0h want ffffffff", grant_count); end
    bus.req_valid = 4'b0100;
    set_lane(2, 64'd3);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    complete_txn(2, 64'd4);
    checks++; if (grant_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %0h want 0", grant_count); end
  endtask

  initial begin
    RST              = 1'b1;
    cnt_load         = 1'b0;
    cnt_load_value   = '0;
    bus.req_valid    = '0;
    bus.req_value    = '0;
    bus.rsp_ready    = '0;
    bus.wu_ready     = 1'b0;
    bus.wu_rsp_valid = 1'b0;
    bus.wu_rsp_value = '0;

    test_reset();
    test_single();
    test_round_robin();
    test_issue_stall();
    test_rsp_hold();
    test_reset_mid();
    test_count_wrap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
